piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 28 ++
 rtl/piso_bit_cnt.sv | 42 ++++
 rtl/piso_serializer.sv | 136 +++++++++++++
 tb/tb_piso_serializer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the PISO serializer. Holds the
//                FSM state type, the frame-length function and the bit
//                counter width expression.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of serial bits per frame: the data word plus an optional
    // trailing parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? (width + 1) : width;
    endfunction

    // Counter must hold values 0..n-1; sized as $clog2(n+1).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_bit_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : piso_bit_cnt
//  Description : Loadable down-counter tracking the remaining bits of a
//                frame. o_zero flags the final bit of the frame.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        : clock, rising-edge active
//    rst_n      : asynchronous active-low reset (count cleared)
//    i_load     : load i_load_val (takes priority over i_en)
//    i_load_val : value loaded at frame start (frame length - 1)
//    i_en       : decrement by one; saturates at zero
//    o_zero     : count equals zero
// ============================================================================
module piso_bit_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : piso_bit_cnt
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out transmitter. Accepts a WIDTH-bit
//                word over valid/ready and sends it one bit per clock with
//                frame-valid and last-bit markers. Back-to-back frames are
//                accepted during the last bit, giving no gap between frames.
//  Revision    : 1.0 - initial release
//
//  Configuration macro
//    PISO_SERIALIZER_PARITY_EN : append an even-parity bit after the data
//
//  Parameters
//    WIDTH     : data word width (2..32)
//    MSB_FIRST : 0 = bit 0 sent first, 1 = bit WIDTH-1 sent first
//
//  Ports
//    clk        : clock, rising-edge active
//    rst_n      : asynchronous active-low reset
//    load_valid : load_data valid this cycle
//    load_ready : serializer can accept a word this cycle
//    load_data  : word to transmit
//    ser_out    : serial data bit (0 outside a frame)
//    ser_valid  : ser_out carries a frame bit
//    ser_last   : final bit of the current frame
//    busy       : frame in progress (same as ser_valid)
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit c_PARITY_EN = 1'b1;
`else
    localparam bit c_PARITY_EN = 1'b0;
`endif

    localparam int              c_N        = frame_len(WIDTH, c_PARITY_EN);
    localparam int              c_CW       = cnt_width(c_N);
    localparam logic [c_CW-1:0] c_LOAD_VAL = c_CW'(c_N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic             w_active;
    logic             w_zero;
    logic             w_accept;
    logic             w_data_bit;

    // All outputs decode from registered state only; load_valid/load_data
    // reach nothing but register inputs.
    assign w_active   = (r_state == SHIFT);
    assign ser_valid  = w_active;
    assign busy       = w_active;
    assign ser_last   = w_active & w_zero;
    assign load_ready = ~w_active | w_zero;
    assign w_accept   = load_valid & load_ready;

    assign w_data_bit = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];

    piso_bit_cnt #(
        .CW (c_CW)
    ) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (c_LOAD_VAL),
        .i_en       (w_active),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_sreg  <= load_data;
                    end
                end
                SHIFT: begin
                    if (w_accept) begin
                        // New frame starts straight out of the last bit.
                        r_sreg <= load_data;
                    end else if (w_zero) begin
                        r_state <= IDLE;
                        r_sreg  <= '0;
                    end else if (MSB_FIRST != 0) begin
                        r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
                    end else begin
                        r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sreg  <= '0;
                end
            endcase
        end
    end

`ifdef PISO_SERIALIZER_PARITY_EN
    // Parity taken from the word at the accept edge; the shift register
    // has been drained of data by the time the parity bit goes out.
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^load_data;
        end
    end

    assign ser_out = w_active & (w_zero ? r_par : w_data_bit);
`else
    assign ser_out = w_active & w_data_bit;
`endif

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. Two instances
//                (LSB-first and MSB-first) share one stimulus stream; a
//                queue-based frame model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;

    logic l_ready, l_out, l_valid, l_last, l_busy;
    logic m_ready, m_out, m_valid, m_last, m_busy;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(l_ready),
        .load_data(load_data), .ser_out(l_out), .ser_valid(l_valid),
        .ser_last(l_last), .busy(l_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(m_ready),
        .load_data(load_data), .ser_out(m_out), .ser_valid(m_valid),
        .ser_last(m_last), .busy(m_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pending serial bits for each bit order. Front = bit on the wire
    // this cycle; the frame ends when one bit remains.
    bit q_l[$];
    bit q_m[$];
    bit m_acc;

    // Observations from the LSB-first / MSB-first instances.
    bit cap_l[$];
    bit cap_m[$];
    int run_len  = 0;
    int max_run  = 0;
    int last_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_l.delete();
            q_m.delete();
        end else begin
            m_acc = load_valid && (q_l.size() <= 1);
            if (q_l.size() > 0) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
            if (m_acc) begin
                for (int i = 0; i < W; i++) begin
                    q_l.push_back(load_data[i]);
                    q_m.push_back(load_data[W-1-i]);
                end
                if (N > W) begin
                    q_l.push_back(^load_data);
                    q_m.push_back(^load_data);
                end
            end
        end
    end

    // Per-cycle comparison, half a period away from the active edge.
    always @(negedge clk) begin
        logic e_v, e_last, e_rdy, e_ol, e_om;
        e_v    = (q_l.size() > 0);
        e_last = (q_l.size() == 1);
        e_rdy  = (q_l.size() <= 1);
        e_ol   = e_v ? q_l[0] : 1'b0;
        e_om   = e_v ? q_m[0] : 1'b0;
        chk("lsb_valid", {31'd0, l_valid}, {31'd0, e_v});
        chk("lsb_busy",  {31'd0, l_busy},  {31'd0, e_v});
        chk("lsb_last",  {31'd0, l_last},  {31'd0, e_last});
        chk("lsb_ready", {31'd0, l_ready}, {31'd0, e_rdy});
        chk("lsb_out",   {31'd0, l_out},   {31'd0, e_ol});
        chk("msb_valid", {31'd0, m_valid}, {31'd0, e_v});
        chk("msb_last",  {31'd0, m_last},  {31'd0, e_last});
        chk("msb_ready", {31'd0, m_ready}, {31'd0, e_rdy});
        chk("msb_out",   {31'd0, m_out},   {31'd0, e_om});
        if (l_valid) cap_l.push_back(l_out);
        if (m_valid) cap_m.push_back(m_out);
        if (l_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (l_last) last_cnt++;
    end

    task automatic clear_obs();
        cap_l.delete();
        cap_m.delete();
        run_len  = 0;
        max_run  = 0;
        last_cnt = 0;
    endtask

    // Bit i of the result = i-th transmitted bit starting at 'base'.
    function automatic logic [W-1:0] word_l(input int base);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++)
            if (base + i < cap_l.size()) v[i] = cap_l[base+i];
        return v;
    endfunction

    function automatic logic [W-1:0] word_m(input int base);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++)
            if (base + i < cap_m.size()) v[i] = cap_m[base+i];
        return v;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!l_ready && t < 4 * N) begin
            @(negedge clk);
            t++;
        end
        if (!l_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: load_ready stayed 0 for %0d cycles", t);
        end
    endtask

    // Present a word and return just after the edge that accepts it;
    // load_valid is left high so a following send runs back-to-back.
    task automatic send(input logic [W-1:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        wait_ready();
        @(posedge clk);
    endtask

    task automatic idle_wait(input int cycles);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a valid word waiting.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, l_ready}, 32'd1);
        chk("rst_valid", {31'd0, l_valid}, 32'd0);
        chk("rst_out",   {31'd0, l_out},   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first_edge_accept", {31'd0, l_valid}, 32'd1);
        chk("first_bit_5a",      {31'd0, l_out},   32'd0);
        load_valid = 1'b0;
        repeat (N + 2) @(negedge clk);

        // Single word, LSB first: 1,0,1,0,0,1,0,1.
        clear_obs();
        send(8'hA5);
        idle_wait(N + 3);
        chk("a5_len",   cap_l.size(), N);
        chk("a5_bits",  {24'd0, word_l(0)}, 32'h0000_00A5);
        chk("a5_lasts", last_cnt, 1);

        // Back-to-back frames with load_valid held high.
        clear_obs();
        send(8'h0F);
        send(8'hF0);
        idle_wait(N + 3);
        chk("b2b_run",   max_run, 2 * N);
        chk("b2b_word0", {24'd0, word_l(0)}, 32'h0000_000F);
        chk("b2b_word1", {24'd0, word_l(N)}, 32'h0000_00F0);

        // MSB first: 8'h81 -> 1,0,0,0,0,0,0,1.
        clear_obs();
        send(8'h81);
        idle_wait(N + 3);
        chk("msb_81", {24'd0, word_m(0)}, 32'h0000_0081);

        // Backpressure; data changes while waiting, only accept-edge value goes out.
        clear_obs();
        send(8'h55);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h3C;
        chk("bp_ready_low", {31'd0, l_ready}, 32'd0);
        repeat (2) @(negedge clk);
        load_data = 8'hC3;
        wait_ready();
        @(posedge clk);
        idle_wait(N + 3);
        chk("bp_word0", {24'd0, word_l(0)}, 32'h0000_0055);
        chk("bp_word1", {24'd0, word_l(N)}, 32'h0000_00C3);
        chk("bp_len",   cap_l.size(), 2 * N);

        // Reset asserted in bit 4 of 8'hFF.
        clear_obs();
        send(8'hFF);
        repeat (3) @(posedge clk);
        #2;
        load_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, l_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, l_valid}, 32'd0);
        chk("async_rst_out",   {31'd0, l_out},   32'd0);
        chk("async_rst_ready", {31'd0, l_ready}, 32'd1);
        chk("async_rst_mvld",  {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (N + 3) @(negedge clk);
        chk("no_residual", cap_l.size(), 0);
        chk("post_rst_ready", {31'd0, l_ready}, 32'd1);

`ifdef PISO_SERIALIZER_PARITY_EN
        clear_obs();
        send(8'h07);
        idle_wait(N + 3);
        chk("par07_len",  cap_l.size(), 9);
        chk("par07_data", {24'd0, word_l(0)}, 32'h0000_0007);
        chk("par07_bit",  {31'd0, cap_l[8]}, 32'd1);
        clear_obs();
        send(8'h03);
        idle_wait(N + 3);
        chk("par03_bit",  {31'd0, cap_l[8]}, 32'd0);
`endif

        // Randomized traffic against the model.
        repeat (800) begin
            @(negedge clk);
            load_valid = (($urandom % 4) != 0);
            load_data  = W'($urandom);
        end
        idle_wait(N + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire
